// File: rtl/serial_setting_bus_pkg.sv
// Shared widths, frame geometry and FSM encoding for the serial setting bus.
package serial_setting_bus_pkg;

    localparam int unsigned DEF_ADDR_W = 7;
    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned FRAME_BITS = 40;
    localparam int unsigned HDR_BITS   = 8;
    localparam int unsigned RW_BIT     = HDR_BITS - 1;
    localparam int unsigned CNT_W      = 6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_WDATA,
        S_RDATA,
        S_DRAIN
    } state_t;

    // Header layout as it sits in the header shifter after eight bits.
    typedef struct packed {
        logic                  rw;
        logic [DEF_ADDR_W-1:0] addr;
    } hdr_t;

endpackage

// File: rtl/serial_setting_bus_sync_edge_detect.sv
// Multi-flop synchroniser for one asynchronous input, with rise/fall pulses
// derived from the synchronised level.
module sync_edge_detect #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset_n,
    input  logic din,
    output logic level,
    output logic rise_c,
    output logic fall_c
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level  = sync_q[SYNC_STAGES-1];
    assign rise_c = level & ~prev_q;
    assign fall_c = ~level & prev_q;

endmodule

// File: rtl/serial_setting_bus.sv
// 3-wire host deserialiser: 40-bit frames become a one-cycle write strobe
// with address/data, or a 32-bit readback shifted out on sdo.
module serial_setting_bus
    import serial_setting_bus_pkg::*;
#(
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              sen,
    input  logic              sclk,
    input  logic              sdata,
    output logic              sdo,
    output logic              sdo_oe,
    output logic              strobe,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data,
    output logic              rb_addr_valid,
    input  logic [DATA_W-1:0] rb_data,
    output logic              frame_error
);

    // Async assert, sync deassert of the internal reset.
    logic [1:0] rst_pipe_q;
    logic       rst_n_int;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) rst_pipe_q <= '0;
        else          rst_pipe_q <= {rst_pipe_q[0], 1'b1};
    end
    assign rst_n_int = rst_pipe_q[1];

    logic sen_lvl, sen_rise_c, sen_fall_c;
    logic sclk_lvl, sclk_rise_c, sclk_fall_c;
    logic sdata_lvl, sdata_rise_c, sdata_fall_c;

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sen (
        .clock(clock), .reset_n(rst_n_int), .din(sen),
        .level(sen_lvl), .rise_c(sen_rise_c), .fall_c(sen_fall_c));

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
        .clock(clock), .reset_n(rst_n_int), .din(sclk),
        .level(sclk_lvl), .rise_c(sclk_rise_c), .fall_c(sclk_fall_c));

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sdata (
        .clock(clock), .reset_n(rst_n_int), .din(sdata),
        .level(sdata_lvl), .rise_c(sdata_rise_c), .fall_c(sdata_fall_c));

    logic unused_edges;
    assign unused_edges = ^{sen_rise_c, sclk_lvl, sdata_rise_c, sdata_fall_c};

    // Only leave IDLE once sen has been seen low with a settled synchroniser,
    // so a frame cut by reset can never be resumed half-way.
    logic [SYNC_STAGES:0] settle_q;
    logic                 armed_q;

    always_ff @(posedge clock or negedge rst_n_int) begin
        if (!rst_n_int) begin
            settle_q <= '0;
            armed_q  <= 1'b0;
        end else begin
            settle_q <= {settle_q[SYNC_STAGES-1:0], 1'b1};
            armed_q  <= armed_q | (settle_q[SYNC_STAGES] & ~sen_lvl);
        end
    end

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [HDR_BITS-1:0] hdr_q;
    logic [DATA_W-1:0]   dsh_q;
    logic [DATA_W-1:0]   obuf_q;
    logic [1:0]          rb_wait_q;
    logic [ADDR_W-1:0]   addr_bak_q;

    logic [CNT_W-1:0]    cnt_inc_c;
    logic [HDR_BITS-1:0] hdr_nx_c;
    logic [DATA_W-1:0]   dsh_nx_c;
    hdr_t                hdr_s_c;
    logic                frame_ok_c;

    // A rise in the same cycle as sen_fall counts before the frame is judged.
    always_comb begin
        cnt_inc_c  = CNT_W'(cnt_q + 1'b1);
        hdr_nx_c   = {hdr_q[HDR_BITS-2:0], sdata_lvl};
        dsh_nx_c   = {dsh_q[DATA_W-2:0], sdata_lvl};
        hdr_s_c    = hdr_t'(hdr_nx_c);
        frame_ok_c = sclk_rise_c ? (cnt_q == CNT_W'(FRAME_BITS - 1))
                                 : (cnt_q == CNT_W'(FRAME_BITS));
    end

    always_ff @(posedge clock or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            hdr_q         <= '0;
            dsh_q         <= '0;
            obuf_q        <= '0;
            rb_wait_q     <= '0;
            addr_bak_q    <= '0;
            addr          <= '0;
            data          <= '0;
            strobe        <= 1'b0;
            rb_addr_valid <= 1'b0;
            frame_error   <= 1'b0;
            sdo           <= 1'b0;
            sdo_oe        <= 1'b0;
        end else begin
            strobe        <= 1'b0;
            rb_addr_valid <= 1'b0;
            frame_error   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (armed_q && sen_lvl) begin
                        state_q <= S_HEADER;
                        cnt_q   <= '0;
                    end
                end
                S_HEADER: begin
                    if (sen_fall_c) begin
                        frame_error <= 1'b1;
                        state_q     <= S_IDLE;
                    end else if (sclk_rise_c) begin
                        hdr_q <= hdr_nx_c;
                        cnt_q <= cnt_inc_c;
                        if (cnt_q == CNT_W'(HDR_BITS - 1)) begin
                            addr_bak_q <= addr;
                            addr       <= ADDR_W'(hdr_s_c.addr);
                            if (hdr_nx_c[RW_BIT]) begin
                                rb_addr_valid <= 1'b1;
                                rb_wait_q     <= 2'd2;
                                sdo_oe        <= 1'b1;
                                state_q       <= S_RDATA;
                            end else begin
                                state_q <= S_WDATA;
                            end
                        end
                    end
                end
                S_WDATA: begin
                    if (sen_fall_c) begin
                        if (frame_ok_c) begin
                            data   <= sclk_rise_c ? dsh_nx_c : dsh_q;
                            strobe <= 1'b1;
                        end else begin
                            frame_error <= 1'b1;
                            addr        <= addr_bak_q;
                        end
                        state_q <= S_IDLE;
                    end else if (sclk_rise_c) begin
                        if (cnt_q == CNT_W'(FRAME_BITS)) begin
                            state_q <= S_DRAIN;
                        end else begin
                            dsh_q <= dsh_nx_c;
                            cnt_q <= cnt_inc_c;
                        end
                    end
                end
                S_RDATA: begin
                    if (sen_fall_c) begin
                        sdo       <= 1'b0;
                        sdo_oe    <= 1'b0;
                        rb_wait_q <= '0;
                        state_q   <= S_IDLE;
                    end else if (rb_wait_q != 2'd0) begin
                        rb_wait_q <= 2'(rb_wait_q - 2'd1);
                        if (rb_wait_q == 2'd1) begin
                            obuf_q <= rb_data;
                            sdo    <= rb_data[DATA_W-1];
                        end
                    end else if (sclk_fall_c) begin
                        obuf_q <= {obuf_q[DATA_W-2:0], 1'b0};
                        sdo    <= obuf_q[DATA_W-2];
                    end
                end
                S_DRAIN: begin
                    if (sen_fall_c) begin
                        frame_error <= 1'b1;
                        addr        <= addr_bak_q;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
